// File: rtl/hazard_stall_ctrl.sv
// Load-use / mult-div hazard controller for the 5-stage MIPS pipeline.
// Optional build macro HAZARD_PERF_EN adds StallCount/FlushCount event counters.
module hazard_stall_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFIDRs,
    input  logic [4:0]  IFIDRt,
    input  logic        IFIDUsesRt,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXRt,
    input  logic        IDBranchTaken,
    input  logic        IDMdStart,
    input  logic        IDMdIsDiv,
    input  logic        IDReadsHiLo,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        MdBusy,
    output logic        MdDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   md_cnt;
    logic [CW-1:0]   md_cnt_nxt;

    logic            load_use;
    logic            md_stall;
    logic            md_last;
    logic            md_issue;

    // Hazard detection; the bubble itself clears IDEXMemRead, so load_use needs no state.
    always_comb begin
        load_use = IDEXMemRead && (IDEXRt != 5'd0) &&
                   ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));
        md_stall = (state == MD_BUSY) && (IDReadsHiLo || IDMdStart);
        md_last  = (state == MD_BUSY) && (md_cnt == CW'(1));
        md_issue = (state == IDLE) && IDMdStart && !load_use;
    end

    // Next-state and pipeline-control outputs.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        MdBusy     = 1'b0;
        MdDone     = 1'b0;

        case (state)
            IDLE: begin
                if (md_issue) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = IDMdIsDiv ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
            end
            MD_BUSY: begin
                MdBusy = 1'b1;
                if (md_last) begin
                    MdDone     = 1'b1;
                    state_nxt  = IDLE;
                    md_cnt_nxt = '0;
                end else begin
                    md_cnt_nxt = md_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = '0;
            end
        endcase

        if (rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
            MdBusy     = 1'b0;
            MdDone     = 1'b0;
        end else if (load_use || md_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (IDBranchTaken) begin
            IFIDFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_ev;
    logic flush_ev;

    always_comb begin
        stall_ev = !rst && (load_use || md_stall);
        flush_ev = !rst && IDBranchTaken && !load_use && !md_stall;
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_ev && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
            if (flush_ev && (FlushCount != 32'hFFFF_FFFF)) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and handles the hazards forwarding cannot resolve. It detects load-use hazards and sequences the multi-cycle mult/div unit with an FSM and countdown counter. It generates PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush for taken branches. Outputs drive the PC register, the IF/ID register and the ID/EX control mux.

Parameters:
MUL_CYCLES, 4, busy cycles for mult/multu (>=1, <=DIV_CYCLES)
DIV_CYCLES, 32, busy cycles for div/divu (>=1)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous active-high reset
IFIDRs  input  5  rs of instruction in ID
IFIDRt  input  5  rt of instruction in ID
IFIDUsesRt  input  1  ID instruction reads rt as a source
IDEXMemRead  input  1  instruction in EX is a load
IDEXRt  input  5  load destination in EX
IDBranchTaken  input  1  branch/jump in ID resolved taken
IDMdStart  input  1  ID instruction is mult/multu/div/divu
IDMdIsDiv  input  1  qualifies IDMdStart: 1=div, 0=mult
IDReadsHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IDEXBubble  output  1  zero ID/EX control signals this cycle
IFIDFlush  output  1  squash IF/ID contents
MdBusy  output  1  mult/div unit occupied
MdDone  output  1  one-cycle pulse, last busy cycle; HI/LO written at its closing edge

Behaviour:
- Clock: one clock domain. Reset: synchronous, active-high; all state updates on the rising clk edge.
- FSM states: IDLE, MD_BUSY. Counter md_cnt, width $clog2(DIV_CYCLES+1).
- Reset (rst=1 at edge): state=IDLE, md_cnt=0. While rst high, outputs are PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=1, MdBusy=0, MdDone=0.
- Reset mid-operation aborts mult/div immediately. No MdDone is emitted.
- load_use (combinational):
  - IDEXMemRead && IDEXRt!=0 && (IDEXRt==IFIDRs || (IFIDUsesRt && IDEXRt==IFIDRt)).
  - Effect: PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly the detect cycle.
  - The bubble clears IDEXMemRead, so the stall releases without state.
- md_stall (combinational): state==MD_BUSY && (IDReadsHiLo || IDMdStart).
  - Effect: same stall outputs as load_use.
  - Unrelated instructions proceed while busy.
- Priority: rst > load_use > md_stall > branch flush > issue.
- IFIDFlush=IDBranchTaken && !load_use && !md_stall. A stalled branch is re-evaluated next cycle.
- Mult/div issue: in IDLE, IDMdStart && !load_use.
  - Next state MD_BUSY; md_cnt=DIV_CYCLES if IDMdIsDiv else MUL_CYCLES.
  - An issue blocked by load_use does not start; it retries next cycle.
- MD_BUSY:
  - MdBusy=1; md_cnt decrements each cycle.
  - When md_cnt==1: MdDone=1; next state IDLE, md_cnt=0.
  - A HiLo reader in ID during the MdDone cycle is stalled. It proceeds the following cycle, i.e. when state is IDLE.
- Back-to-back mult/div: the second is stalled until IDLE, then issues in that IDLE cycle. MdBusy reasserts at the next edge.
- MdBusy=0, MdDone=0 in IDLE.
- Non-stall, non-flush cycle: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments each non-reset cycle with load_use||md_stall.
  - FlushCount increments each cycle with IFIDFlush=1 and rst=0.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: IDEXMemRead=1, IDEXRt=8, IFIDRs=8 for 1 cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 that cycle only. Repeat with IDEXRt=0 -> no stall.
- rt gating: IDEXRt=9, IFIDRt=9, IFIDUsesRt=0 -> no stall; IFIDUsesRt=1 -> 1-cycle stall.
- Divide: IDMdStart=1, IDMdIsDiv=1 at cycle 0 -> MdBusy=1 cycles 1..32, MdDone=1 only cycle 32; mfhi in ID from cycle 5 stalls through cycle 32 and releases at cycle 33.
- Priority: load_use and IDBranchTaken together -> stall, IFIDFlush=0. Next cycle with load_use clear -> IFIDFlush=1.
- Reset at cycle 2 of a MUL_CYCLES=4 multiply -> next cycle MdBusy=0, MdDone never pulses, IFIDFlush=1 and IDEXBubble=1 while rst high.
- HAZARD_PERF_EN: 3 load-use stalls + 2 taken branches -> StallCount=3, FlushCount=2; rst -> both 0.
